uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/uart_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART clocking defaults and transmitter state encoding
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;
  localparam int unsigned UART_CLK_FREQ  = 27_000_000;
  localparam int unsigned UART_BAUD_RATE = 115_200;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock byte FIFO, power-of-two depth, push/pop/full/empty/count
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  // Pointers are exactly log2(DEPTH) wide, so natural overflow wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= push ? wptr + 1'b1 : wptr;
      rptr  <= pop ? rptr + 1'b1 : rptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end
  assign rdata = mem[rptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1 by default
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
  parameter int unsigned BAUD_RATE  = UART_BAUD_RATE,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int unsigned DIV_CNT = CLK_FREQ / BAUD_RATE;
  localparam int DW = $clog2(DIV_CNT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_CNT - 1);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic          tx_d;
  logic [CW-1:0] count_nxt;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif
  assign push      = tx_valid & tx_ready & ~fifo_full;
  assign bit_end   = div_cnt == DIV_LAST;
  assign pop       = ~fifo_empty & (state == IDLE | (state == STOP & bit_end));
  assign count_nxt = fifo_count + CW'(push) - CW'(pop);
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
  // tx_ready looks at next-cycle occupancy so a push can never land on a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      div_cnt  <= (state == IDLE || bit_end) ? '0 : div_cnt + 1'b1;
      bit_cnt  <= (state == DATA && bit_end) ? bit_cnt + 1'b1 : bit_cnt;
      shreg    <= pop ? fifo_rdata : (state == DATA && bit_end) ? shreg >> 1 : shreg;
      tx       <= tx_d;
      tx_ready <= count_nxt != CW'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
      par      <= pop ? ^fifo_rdata : par;
`endif
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = fifo_empty ? IDLE : START;
      START:  state_nxt = bit_end ? DATA : START;
      DATA:   state_nxt = (bit_end && &bit_cnt) ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
      PARITY: state_nxt = bit_end ? STOP : PARITY;
`endif
      STOP:   state_nxt = bit_end ? (fifo_empty ? IDLE : START) : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par;
`endif
      default: tx_d = 1'b1;
    endcase
    tx_busy = state != IDLE;
  end
endmodule
